// File: rtl/oled_spi_arb_if.sv
// Requester/spi_master bundle for oled_spi_arb: two byte requesters on one side,
// the spi_master byte channel on the other.
interface oled_spi_arb_if;
  logic       req0, req1;
  logic       lock0, lock1;
  logic       dc0, dc1;
  logic [7:0] data0, data1;
  logic       ack0, ack1;
  logic [1:0] grant;
  logic       send_en;
  logic       send_dc;
  logic [7:0] send_data;
  logic       send_busy;
  logic       err_to;

  modport slave (
    input  req0, req1, lock0, lock1, dc0, dc1, data0, data1, send_busy,
    output ack0, ack1, grant, send_en, send_dc, send_data, err_to
  );

  modport master (
    output req0, req1, lock0, lock1, dc0, dc1, data0, data1, send_busy,
    input  ack0, ack1, grant, send_en, send_dc, send_data, err_to
  );
endinterface

// File: rtl/oled_spi_arb.sv
// Per-byte round-robin arbiter sharing one spi_master byte channel between the
// frame sequencer (req 0) and the command/text writer (req 1), with burst locking.
module oled_spi_arb #(
  parameter int LOCK_MAX = 16,
  parameter int GAP_CYC  = 2,
  parameter int BUSY_TO  = 64   // must be >= 1
) (
  input logic            clk,
  input logic            rst_n,
  oled_spi_arb_if.slave  bus
);
  localparam int BW = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;
  localparam int TW = (BUSY_TO > 1)  ? $clog2(BUSY_TO + 1)  : 1;
  localparam int GW = (GAP_CYC > 1)  ? $clog2(GAP_CYC + 1)  : 1;

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, GAP} state_t;

  state_t          state_q;
  logic [1:0]      grant_q, ack_q;
  logic            send_en_q, send_dc_q, err_to_q;
  logic [7:0]      send_data_q;
  logic [BW-1:0]   burst_cnt_q;
  logic            rr_last_q, keep_q;
  logic [TW-1:0]   to_cnt_q;
  logic [GW-1:0]   gap_cnt_q;

  logic [1:0]      req, lock, dc;
  logic [1:0][7:0] data;
  assign req  = {bus.req1,  bus.req0};
  assign lock = {bus.lock1, bus.lock0};
  assign dc   = {bus.dc1,   bus.dc0};
  assign data = {bus.data1, bus.data0};

  // A non-zero grant in IDLE means the bus is held by a locked owner.
  logic          own_vld, own, issue_d, win_d, keep_d;
  logic [BW-1:0] burst_cnt_d;
  assign own_vld = |grant_q;
  assign own     = grant_q[1];

  always_comb begin
    win_d   = 1'b0;
    issue_d = 1'b0;
    if (own_vld) begin
      win_d   = own;
      issue_d = req[own];
    end else if (&req) begin
      win_d   = ~rr_last_q;
      issue_d = 1'b1;
    end else if (|req) begin
      win_d   = req[1];
      issue_d = 1'b1;
    end
    if (bus.send_busy) issue_d = 1'b0;
  end

  assign burst_cnt_d = !own_vld ? BW'(1) :
                       (&burst_cnt_q) ? burst_cnt_q : burst_cnt_q + 1'b1;
  assign keep_d      = lock[win_d] && (LOCK_MAX == 0 || int'(burst_cnt_d) < LOCK_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ack_q       <= '0;
      send_en_q   <= 1'b0;
      send_dc_q   <= 1'b0;
      send_data_q <= '0;
      err_to_q    <= 1'b0;
      burst_cnt_q <= '0;
      rr_last_q   <= 1'b1;
      keep_q      <= 1'b0;
      to_cnt_q    <= '0;
      gap_cnt_q   <= '0;
    end else begin
      send_en_q <= 1'b0;
      ack_q     <= '0;
      err_to_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (issue_d) begin
            send_en_q   <= 1'b1;
            ack_q       <= win_d ? 2'b10 : 2'b01;
            grant_q     <= win_d ? 2'b10 : 2'b01;
            send_data_q <= data[win_d];
            send_dc_q   <= dc[win_d];
            rr_last_q   <= win_d;
            burst_cnt_q <= burst_cnt_d;
            keep_q      <= keep_d;
            to_cnt_q    <= '0;
            state_q     <= WAIT_HI;
          end else if (own_vld && !req[own] && !lock[own]) begin
            grant_q     <= '0;
            burst_cnt_q <= '0;
          end
        end
        WAIT_HI: begin
          if (bus.send_busy) begin
            state_q <= WAIT_LO;
          end else if (to_cnt_q == TW'(BUSY_TO - 1)) begin
            // spi_master never started: drop the byte rather than retry
            err_to_q  <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!bus.send_busy) begin
            gap_cnt_q <= '0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          if (GAP_CYC == 0 || int'(gap_cnt_q) >= GAP_CYC - 1) begin
            state_q <= IDLE;
            if (!keep_q) begin
              grant_q     <= '0;
              burst_cnt_q <= '0;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0      = ack_q[0];
  assign bus.ack1      = ack_q[1];
  assign bus.grant     = grant_q;
  assign bus.send_en   = send_en_q;
  assign bus.send_dc   = send_dc_q;
  assign bus.send_data = send_data_q;
  assign bus.err_to    = err_to_q;
endmodule

// File: tb/tb_oled_spi_arb.sv
// Bench for oled_spi_arb: queue-driven requesters, a simple spi_master busy model
// and a byte-level arbitration reference model.
module tb_oled_spi_arb;
  localparam int LM  = 4;
  localparam int GAP = 2;
  localparam int BTO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oled_spi_arb_if bus();
  oled_spi_arb #(.LOCK_MAX(LM), .GAP_CYC(GAP), .BUSY_TO(BTO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  // queue entries: {lock, dc, data}
  logic [9:0] q0[$], q1[$], m0[$], m1[$];
  // issue/expect entries: {owner, dc, data}
  logic [9:0] exp_q[$], iss_v[$];
  int iss_t[$], err_t[$];
  int proto_bad = 0;
  int busy_rem = 0;
  int busy_len = 4;
  bit spi_on = 1'b1;
  bit busy_force = 1'b0;
  bit tmo = 1'b0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive();
    bus.req0  = (q0.size() > 0);
    bus.lock0 = (q0.size() > 0) ? q0[0][9] : 1'b0;
    bus.dc0   = (q0.size() > 0) ? q0[0][8] : 1'b0;
    bus.data0 = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    bus.req1  = (q1.size() > 0);
    bus.lock1 = (q1.size() > 0) ? q1[0][9] : 1'b0;
    bus.dc1   = (q1.size() > 0) ? q1[0][8] : 1'b0;
    bus.data1 = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
  endtask

  task automatic step();
    logic who;
    @(negedge clk);
    cyc++;
    if (bus.send_en !== (bus.ack0 | bus.ack1) || (bus.ack0 & bus.ack1)) proto_bad++;
    if (bus.send_en === 1'b1) begin
      who = bus.ack1;
      if (bus.grant !== (who ? 2'b10 : 2'b01)) proto_bad++;
      iss_t.push_back(cyc);
      iss_v.push_back({who, bus.send_dc, bus.send_data});
      if (spi_on) busy_rem = busy_len;
    end
    if (bus.err_to === 1'b1) err_t.push_back(cyc);
    bus.send_busy = busy_force || (busy_rem > 0);
    if (busy_rem > 0) busy_rem--;
    if (bus.ack0 === 1'b1 && q0.size() > 0) void'(q0.pop_front());
    if (bus.ack1 === 1'b1 && q1.size() > 0) void'(q1.pop_front());
    drive();
  endtask

  task automatic run_done(input int budget);
    int idle = 0;
    int n = 0;
    tmo = 1'b0;
    while (idle < 30) begin
      step();
      n++;
      if (q0.size() > 0 || q1.size() > 0 || bus.send_busy) idle = 0;
      else idle++;
      if (n > budget) begin
        tmo = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    drive();
    busy_rem = 0; busy_force = 1'b0; spi_on = 1'b1;
    bus.send_busy = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    iss_t.delete(); iss_v.delete(); err_t.delete();
    proto_bad = 0;
  endtask

  // Byte-level reference: decide each byte's owner from the arbitration rules.
  task automatic model_build();
    int own, cnt, rr, w;
    logic [9:0] e;
    own = -1; cnt = 0; rr = 1;
    m0 = q0; m1 = q1;
    exp_q.delete();
    while (m0.size() > 0 || m1.size() > 0) begin
      if (own == 0 && m0.size() == 0) own = -1;
      if (own == 1 && m1.size() == 0) own = -1;
      if (own >= 0) w = own;
      else if (m0.size() > 0 && m1.size() > 0) w = 1 - rr;
      else w = (m0.size() > 0) ? 0 : 1;
      if (w == 1) e = m1.pop_front();
      else        e = m0.pop_front();
      cnt = (own == w) ? cnt + 1 : 1;
      own = (e[9] && cnt < LM) ? w : -1;
      rr  = w;
      exp_q.push_back({w[0], e[8:0]});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    q0.push_back({1'b0, 1'b1, 8'hFF});
    drive();
    repeat (4) @(negedge clk);
    #1;
    tests_run++;
    if (bus.grant !== 2'b00) begin
      tests_failed++; $display("FAIL reset_grant: got %b want 00", bus.grant);
    end
    tests_run++;
    if ({bus.send_en, bus.ack0, bus.ack1, bus.err_to, bus.send_dc} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b want 00000",
               {bus.send_en, bus.ack0, bus.ack1, bus.err_to, bus.send_dc});
    end
    tests_run++;
    if (bus.send_data !== 8'h00) begin
      tests_failed++; $display("FAIL reset_data: got %h want 00", bus.send_data);
    end
  endtask

  task automatic test_single();
    int c0;
    do_reset();
    busy_len = 10;
    q0.push_back({1'b0, 1'b0, 8'hAE});
    q0.push_back({1'b0, 1'b1, 8'h3C});
    c0 = cyc + 1;
    run_done(400);
    tests_run++;
    if (tmo || iss_t.size() != 2) begin
      tests_failed++; $display("FAIL single_count: got %0d issues tmo=%0d want 2", iss_t.size(), tmo);
    end else begin
      tests_run++;
      if (iss_t[0] != c0 + 1) begin
        tests_failed++; $display("FAIL single_latency: got cycle %0d want %0d", iss_t[0], c0 + 1);
      end
      tests_run++;
      if (iss_v[0] !== {1'b0, 1'b0, 8'hAE}) begin
        tests_failed++; $display("FAIL single_byte0: got %h want %h", iss_v[0], {1'b0, 1'b0, 8'hAE});
      end
      tests_run++;
      if (iss_v[1] !== {1'b0, 1'b1, 8'h3C}) begin
        tests_failed++; $display("FAIL single_byte1: got %h want %h", iss_v[1], {1'b0, 1'b1, 8'h3C});
      end
      tests_run++;
      if (iss_t[1] - iss_t[0] < 10 + GAP) begin
        tests_failed++; $display("FAIL single_spacing: got %0d want >= %0d", iss_t[1] - iss_t[0], 10 + GAP);
      end
    end
    tests_run++;
    if (proto_bad != 0) begin
      tests_failed++; $display("FAIL single_proto: got %0d violations want 0", proto_bad);
    end
  endtask

  task automatic test_rr();
    do_reset();
    busy_len = 3;
    for (int i = 0; i < 3; i++) begin
      q0.push_back({1'b0, 1'($urandom), 8'($urandom)});
      q1.push_back({1'b0, 1'($urandom), 8'($urandom)});
    end
    model_build();
    run_done(600);
    tests_run++;
    if (tmo || iss_v.size() != 6) begin
      tests_failed++; $display("FAIL rr_count: got %0d tmo=%0d want 6", iss_v.size(), tmo);
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (iss_v[i] !== exp_q[i] || iss_v[i][9] !== 1'(i % 2)) begin
          tests_failed++; $display("FAIL rr_byte%0d: got %h want %h", i, iss_v[i], exp_q[i]);
        end
      end
    end
    tests_run++;
    if (proto_bad != 0) begin
      tests_failed++; $display("FAIL rr_proto: got %0d violations want 0", proto_bad);
    end
  endtask

  task automatic test_lock();
    logic [9:0] ex [5];
    int n;
    ex = '{{1'b1, 1'b0, 8'hA1}, {1'b1, 1'b1, 8'hA2}, {1'b1, 1'b1, 8'hA3},
           {1'b0, 1'b0, 8'hB1}, {1'b0, 1'b1, 8'hB2}};
    do_reset();
    busy_len = 4;
    q1.push_back({1'b1, 1'b0, 8'hA1});
    q1.push_back({1'b1, 1'b1, 8'hA2});
    q1.push_back({1'b0, 1'b1, 8'hA3});
    n = 0;
    while (iss_t.size() == 0 && n < 50) begin
      step();
      n++;
    end
    q0.push_back({1'b0, 1'b0, 8'hB1});
    q0.push_back({1'b0, 1'b1, 8'hB2});
    run_done(600);
    tests_run++;
    if (tmo || iss_v.size() != 5) begin
      tests_failed++; $display("FAIL lock_count: got %0d tmo=%0d want 5", iss_v.size(), tmo);
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (iss_v[i] !== ex[i]) begin
          tests_failed++; $display("FAIL lock_byte%0d: got %h want %h", i, iss_v[i], ex[i]);
        end
      end
    end
  endtask

  task automatic test_lock_max();
    int ord [12];
    ord = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    do_reset();
    busy_len = 2;
    for (int i = 0; i < 10; i++) q0.push_back({1'b1, 1'b1, 8'(8'h10 + i)});
    for (int i = 0; i < 2; i++)  q1.push_back({1'b0, 1'b0, 8'(8'hC0 + i)});
    model_build();
    run_done(1000);
    tests_run++;
    if (tmo || iss_v.size() != 12) begin
      tests_failed++; $display("FAIL lockmax_count: got %0d tmo=%0d want 12", iss_v.size(), tmo);
    end else begin
      for (int i = 0; i < 12; i++) begin
        tests_run++;
        if (iss_v[i] !== exp_q[i] || int'(iss_v[i][9]) != ord[i]) begin
          tests_failed++; $display("FAIL lockmax_byte%0d: got %h want %h owner %0d", i, iss_v[i], exp_q[i], ord[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int n0, n1;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      busy_len = $urandom_range(1, 6);
      n0 = $urandom_range(1, 8);
      n1 = $urandom_range(1, 8);
      for (int i = 0; i < n0; i++) q0.push_back(10'($urandom));
      for (int i = 0; i < n1; i++) q1.push_back(10'($urandom));
      model_build();
      run_done(2000);
      tests_run++;
      if (tmo || iss_v.size() != exp_q.size()) begin
        tests_failed++; $display("FAIL rand%0d_count: got %0d tmo=%0d want %0d", r, iss_v.size(), tmo, exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          tests_run++;
          if (iss_v[i] !== exp_q[i]) begin
            tests_failed++; $display("FAIL rand%0d_byte%0d: got %h want %h", r, i, iss_v[i], exp_q[i]);
          end
        end
      end
      tests_run++;
      if (proto_bad != 0) begin
        tests_failed++; $display("FAIL rand%0d_proto: got %0d violations want 0", r, proto_bad);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    spi_on = 1'b0;
    q0.push_back({1'b0, 1'b0, 8'h55});
    q0.push_back({1'b0, 1'b1, 8'h66});
    run_done(400);
    tests_run++;
    if (tmo || iss_t.size() != 2 || err_t.size() != 2) begin
      tests_failed++;
      $display("FAIL timeout_count: got %0d issues %0d errs tmo=%0d want 2 2", iss_t.size(), err_t.size(), tmo);
    end else begin
      tests_run++;
      if (err_t[0] - iss_t[0] != BTO) begin
        tests_failed++; $display("FAIL timeout_delay0: got %0d want %0d", err_t[0] - iss_t[0], BTO);
      end
      tests_run++;
      if (err_t[1] - iss_t[1] != BTO) begin
        tests_failed++; $display("FAIL timeout_delay1: got %0d want %0d", err_t[1] - iss_t[1], BTO);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    busy_len = 40;
    q0.push_back({1'b0, 1'b1, 8'h5A});
    repeat (6) step();
    tests_run++;
    if (bus.grant !== 2'b01 || bus.send_data !== 8'h5A) begin
      tests_failed++; $display("FAIL rstmid_pre: got grant %b data %h want 01 5a", bus.grant, bus.send_data);
    end
    busy_force = 1'b1;
    bus.send_busy = 1'b1;
    busy_rem = 0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.grant, bus.send_en, bus.ack0, bus.ack1, bus.err_to, bus.send_dc, bus.send_data} !== 15'b0) begin
      tests_failed++;
      $display("FAIL rstmid_clear: got grant %b dc %b data %h want all zero", bus.grant, bus.send_dc, bus.send_data);
    end
    q0.delete();
    q0.push_back({1'b0, 1'b0, 8'hC3});
    drive();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    iss_t.delete(); iss_v.delete();
    repeat (10) step();
    tests_run++;
    if (iss_t.size() != 0) begin
      tests_failed++; $display("FAIL rstmid_hold: got %0d issues while busy want 0", iss_t.size());
    end
    busy_force = 1'b0;
    run_done(200);
    tests_run++;
    if (tmo || iss_v.size() != 1) begin
      tests_failed++; $display("FAIL rstmid_resume: got %0d issues tmo=%0d want 1", iss_v.size(), tmo);
    end else begin
      tests_run++;
      if (iss_v[0] !== {1'b0, 1'b0, 8'hC3}) begin
        tests_failed++; $display("FAIL rstmid_byte: got %h want %h", iss_v[0], {1'b0, 1'b0, 8'hC3});
      end
    end
  endtask

  initial begin
    bus.send_busy = 1'b0;
    drive();
    test_reset();
    test_single();
    test_rr();
    test_lock();
    test_lock_max();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
